sd_block_read: RTL and testbench
================================

SD_BLOCK_READ -- requirements
Module: sd_block_read

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCLK half-period, minimum 2.
REQ-002 SHALL have parameter TOKEN_TIMEOUT, default 4096: maximum bytes polled for the data token.
REQ-003 SHALL have port clk, input, 1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port DO, input, 1: card MISO.
REQ-006 SHALL have port SCLK, output, 1: SPI clock to card.
REQ-007 SHALL have port DI, output, 1: card MOSI.
REQ-008 SHALL have port CS, output, 1: card chip select, active-low.
REQ-009 SHALL have port isStart, input, 1: read request, sampled only in IDLE.
REQ-010 SHALL have port blockAddr, input, 32: block number, latched with isStart.
REQ-011 SHALL have port isHighCap, input, 1: 1 = SDHC block addressing; 0 = byte addressing. Latched with isStart.
REQ-012 SHALL have port dataOut, output, 8: received data byte.
REQ-013 SHALL have port dataValid, output, 1: one-clk strobe qualifying dataOut.
REQ-014 SHALL have port isBusy, output, 1: high from the isStart acceptance through DONE/ERROR.
REQ-015 SHALL have port isFinish, output, 1: level; block read completed OK.
REQ-016 SHALL have port isError, output, 1: level; read aborted.
REQ-017 SHALL have port errCode, output, 8: failing R1 byte or error token; 8'hFF on timeout.

Function
REQ-018 SHALL derive an SCLK edge tick every CLK_DIV clk cycles. SCLK toggles only while a byte is shifting; it idles low (SPI mode 0).
REQ-019 SHALL update DI after each SCLK falling edge, MSB first. SHALL sample DO on each SCLK rising edge.
REQ-020 SHALL use state sequence IDLE -> CMD -> WAIT_R1 -> WAIT_TOKEN -> DATA -> CRC -> TRAIL -> DONE, with ERROR reachable from WAIT_R1 and WAIT_TOKEN.
REQ-021 IDLE: CS=1, DI=1. isStart=1 latches the inputs, clears isFinish/isError, and enters CMD on the next clk.
REQ-022 CMD: CS=0. Sends 6 bytes: 8'h51, argument[31:24..7:0], 8'hFF.
REQ-023 Argument SHALL be blockAddr when isHighCap=1. Otherwise {blockAddr[22:0], 9'b0}, truncated to 32 bits.
REQ-024 WAIT_R1: clocks bytes with DI=1. The first byte with bit7=0 is R1.
REQ-025 R1=8'h00 SHALL enter WAIT_TOKEN. Any other R1 SHALL enter ERROR with errCode=R1.
REQ-026 No R1 within 8 bytes SHALL enter ERROR with errCode=8'hFF.
REQ-027 WAIT_TOKEN: byte 8'hFE SHALL enter DATA.
REQ-028 In WAIT_TOKEN, a byte matching 8'b000x_xxxx SHALL enter ERROR with errCode=that byte.
REQ-029 In WAIT_TOKEN, 8'hFF SHALL continue polling. TOKEN_TIMEOUT bytes polled without a token SHALL enter ERROR with errCode=8'hFF.
REQ-030 In WAIT_TOKEN, any other byte SHALL be ignored and counts toward the timeout.
REQ-031 DATA: exactly 512 bytes; byte counter 10 bits wide, 0..511.
REQ-032 Each byte SHALL appear on dataOut with dataValid=1 for one clk, on the clk after its 8th rising edge.
REQ-033 dataOut SHALL hold its value until the next byte arrives.
REQ-034 CRC: two bytes SHALL be clocked and discarded, with no dataValid.
REQ-035 TRAIL: CS=1, DI=1, then 8 SCLK cycles, then DONE.
REQ-036 DONE: isFinish=1, isBusy=0. A new isStart SHALL be accepted exactly as in IDLE.
REQ-037 ERROR: CS=1, DI=1, isError=1, isBusy=0. A new isStart restarts from CMD.
REQ-038 isStart while isBusy=1 SHALL be ignored.

Reset
REQ-039 reset=0 SHALL force IDLE asynchronously, including mid-transfer; no partial bytes are emitted afterwards.
REQ-040 Reset values: SCLK=0, DI=1, CS=1, dataOut=8'h00, dataValid=0, isBusy=0, isFinish=0, isError=0, errCode=8'h00; all counters 0.

Structure
REQ-041 A shared package sd_pkg SHALL hold: CMD17 index, data token 8'hFE, R1 poll limit 8, block size 512, and the state enumeration.
REQ-042 Byte shifting SHALL live in one sub-module, sd_spi_byte.
REQ-043 sd_spi_byte SHALL take txByte, start and tick, and return rxByte and done; it owns SCLK, DI and the bit counter.

Verification
REQ-044 Scenario: isHighCap=1, blockAddr=32'h0000_0010, card answers R1=00 after 2 FF bytes, FE after 5 FF bytes, data = index mod 256. Required: command bytes 51 00 00 00 10 FF; 512 dataValid pulses carrying 00..FF twice; isFinish=1; exactly 8 trailing SCLK cycles with CS=1.
REQ-045 Scenario: isHighCap=0, blockAddr=3. Required: argument bytes 00 00 06 00.
REQ-046 Scenario: card returns R1=8'h04. Required: isError=1, errCode=04, zero dataValid pulses, CS=1.
REQ-047 Scenario: card returns error token 8'h08 in WAIT_TOKEN. Required: isError=1, errCode=08.
REQ-048 Scenario: DO held at 1 throughout. Required: ERROR after 8 R1 bytes with errCode=FF. Separately, with R1=00 and no token, ERROR after TOKEN_TIMEOUT bytes.
REQ-049 Scenario: reset=0 asserted at data byte 100. Required: same-cycle CS=1 and SCLK=0, no further dataValid; after release, a new isStart completes a full 512-byte read.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SD-card SPI block reader.
package sd_pkg;

    localparam logic [5:0] CMD17_IDX     = 6'd17;
    localparam logic [7:0] DATA_TOKEN    = 8'hFE;
    localparam int         R1_POLL_LIMIT = 8;
    localparam int         BLOCK_SIZE    = 512;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_WAIT_R1,
        S_WAIT_TOKEN,
        S_DATA,
        S_CRC,
        S_TRAIL,
        S_DONE,
        S_ERROR
    } sdState_t;

endpackage

// File: rtl/sd_spi_byte.sv
// SPI mode-0 byte shifter: one byte out on DI and in from DO, MSB first.
module sd_spi_byte
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [7:0] txByte,
    input  logic       DO,
    output logic [7:0] rxByte,
    output logic       done,
    output logic       busy,
    output logic       SCLK,
    output logic       DI
);

    logic [2:0] bitCnt;
    logic [7:0] txShift;

    // DI is the MSB of the shift register, which idles at all-ones between bytes.
    assign DI = txShift[7];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitCnt  <= 3'd0;
            txShift <= 8'hFF;
            rxByte  <= 8'h00;
            done    <= 1'b0;
            busy    <= 1'b0;
            SCLK    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy    <= 1'b1;
                    bitCnt  <= 3'd0;
                    txShift <= txByte;
                end
            end else if (tick) begin
                if (!SCLK) begin
                    SCLK   <= 1'b1;
                    rxByte <= {rxByte[6:0], DO};
                    // done marks the 8th rising edge; the byte still owns the final low half.
                    done   <= (bitCnt == 3'd7);
                end else begin
                    SCLK    <= 1'b0;
                    txShift <= {txShift[6:0], 1'b1};
                    if (bitCnt == 3'd7) begin
                        busy <= 1'b0;
                    end else begin
                        bitCnt <= bitCnt + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sd_block_read.sv
// SD-card single-block read (CMD17) over SPI: command, R1, token, 512 data bytes, CRC, trailer.
module sd_block_read
    import sd_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int TOKEN_TIMEOUT = 4096
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        DO,
    output logic        SCLK,
    output logic        DI,
    output logic        CS,
    input  logic        isStart,
    input  logic [31:0] blockAddr,
    input  logic        isHighCap,
    output logic [7:0]  dataOut,
    output logic        dataValid,
    output logic        isBusy,
    output logic        isFinish,
    output logic        isError,
    output logic [7:0]  errCode
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int POLL_W = $clog2((TOKEN_TIMEOUT > R1_POLL_LIMIT) ? TOKEN_TIMEOUT : R1_POLL_LIMIT) + 1;

    sdState_t          state;
    logic [DIV_W-1:0]  divCnt;
    logic [2:0]        cmdIdx;
    logic [POLL_W-1:0] pollCnt;
    logic [9:0]        byteCnt;
    logic              crcCnt;
    logic [31:0]       arg;
    logic [7:0]        txByte;
    logic [7:0]        rxByte;
    logic              byteDone;
    logic              byteBusy;
    logic              byteStart;
    logic              tick;
    logic              shifting;

    assign shifting  = state inside {S_CMD, S_WAIT_R1, S_WAIT_TOKEN, S_DATA, S_CRC, S_TRAIL};
    assign byteStart = shifting && !byteBusy;
    assign tick      = byteBusy && (divCnt == DIV_W'(CLK_DIV - 1));

    always_comb begin
        txByte = 8'hFF;
        if (state == S_CMD) begin
            case (cmdIdx)
                3'd0:    txByte = {2'b01, CMD17_IDX};
                3'd1:    txByte = arg[31:24];
                3'd2:    txByte = arg[23:16];
                3'd3:    txByte = arg[15:8];
                3'd4:    txByte = arg[7:0];
                default: txByte = 8'hFF;
            endcase
        end
    end

    sd_spi_byte u_byte (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .start  (byteStart),
        .txByte (txByte),
        .DO     (DO),
        .rxByte (rxByte),
        .done   (byteDone),
        .busy   (byteBusy),
        .SCLK   (SCLK),
        .DI     (DI)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            divCnt    <= '0;
            cmdIdx    <= 3'd0;
            pollCnt   <= '0;
            byteCnt   <= 10'd0;
            crcCnt    <= 1'b0;
            arg       <= 32'h0;
            CS        <= 1'b1;
            dataOut   <= 8'h00;
            dataValid <= 1'b0;
            isBusy    <= 1'b0;
            isFinish  <= 1'b0;
            isError   <= 1'b0;
            errCode   <= 8'h00;
        end else begin
            dataValid <= 1'b0;
            // Divider restarts with every byte so each first SCLK edge is a full half-period after DI.
            if (!byteBusy || tick) divCnt <= '0;
            else                   divCnt <= divCnt + 1'b1;

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (isStart) begin
                        arg      <= isHighCap ? blockAddr : {blockAddr[22:0], 9'b0};
                        isFinish <= 1'b0;
                        isError  <= 1'b0;
                        isBusy   <= 1'b1;
                        CS       <= 1'b0;
                        cmdIdx   <= 3'd0;
                        state    <= S_CMD;
                    end
                end
                S_CMD: if (byteDone) begin
                    if (cmdIdx == 3'd5) begin
                        pollCnt <= '0;
                        state   <= S_WAIT_R1;
                    end else begin
                        cmdIdx <= cmdIdx + 3'd1;
                    end
                end
                S_WAIT_R1: if (byteDone) begin
                    if (!rxByte[7]) begin
                        if (rxByte == 8'h00) begin
                            pollCnt <= '0;
                            state   <= S_WAIT_TOKEN;
                        end else begin
                            errCode <= rxByte;
                            isError <= 1'b1;
                            isBusy  <= 1'b0;
                            CS      <= 1'b1;
                            state   <= S_ERROR;
                        end
                    end else if (pollCnt == POLL_W'(R1_POLL_LIMIT - 1)) begin
                        errCode <= 8'hFF;
                        isError <= 1'b1;
                        isBusy  <= 1'b0;
                        CS      <= 1'b1;
                        state   <= S_ERROR;
                    end else begin
                        pollCnt <= pollCnt + 1'b1;
                    end
                end
                S_WAIT_TOKEN: if (byteDone) begin
                    if (rxByte == DATA_TOKEN) begin
                        byteCnt <= 10'd0;
                        state   <= S_DATA;
                    end else if (rxByte[7:5] == 3'b000) begin
                        errCode <= rxByte;
                        isError <= 1'b1;
                        isBusy  <= 1'b0;
                        CS      <= 1'b1;
                        state   <= S_ERROR;
                    end else if (pollCnt == POLL_W'(TOKEN_TIMEOUT - 1)) begin
                        errCode <= 8'hFF;
                        isError <= 1'b1;
                        isBusy  <= 1'b0;
                        CS      <= 1'b1;
                        state   <= S_ERROR;
                    end else begin
                        pollCnt <= pollCnt + 1'b1;
                    end
                end
                S_DATA: if (byteDone) begin
                    dataOut   <= rxByte;
                    dataValid <= 1'b1;
                    if (byteCnt == 10'(BLOCK_SIZE - 1)) begin
                        crcCnt <= 1'b0;
                        state  <= S_CRC;
                    end else begin
                        byteCnt <= byteCnt + 10'd1;
                    end
                end
                S_CRC: if (byteDone) begin
                    if (crcCnt) begin
                        CS    <= 1'b1;
                        state <= S_TRAIL;
                    end else begin
                        crcCnt <= 1'b1;
                    end
                end
                S_TRAIL: if (byteDone) begin
                    isFinish <= 1'b1;
                    isBusy   <= 1'b0;
                    state    <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_read.sv
// Bench for sd_block_read: scripted SD card on the SPI pins with command and data scoreboards.
module tb_sd_block_read;

    localparam int CLK_DIV       = 2;
    localparam int TOKEN_TIMEOUT = 16;
    localparam int READ_LIMIT    = 30000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        DO;
    logic        SCLK;
    logic        DI;
    logic        CS;
    logic        isStart = 1'b0;
    logic [31:0] blockAddr = 32'h0;
    logic        isHighCap = 1'b0;
    logic [7:0]  dataOut;
    logic        dataValid;
    logic        isBusy;
    logic        isFinish;
    logic        isError;
    logic [7:0]  errCode;

    int nAsserts = 0;
    int nFails   = 0;

    // card script
    int         r1Delay  = 0;
    int         tokDelay = 0;
    logic [7:0] r1Val    = 8'h00;
    logic [7:0] tokVal   = 8'hFE;
    bit         noR1     = 1'b0;
    bit         noTok    = 1'b0;

    logic [7:0] cmdQ[$];
    logic [7:0] expQ[$];
    int cardBytes  = 0;
    int dvCount    = 0;
    int trailRises = 0;
    int baseBytes, baseDv, baseTrail;

    logic [7:0] misoSh = 8'hFF;
    logic [7:0] mosiSh = 8'h00;
    int         cardBit = 0;
    int         byteNum = 0;

    always #5 clk = ~clk;

    sd_block_read #(.CLK_DIV(CLK_DIV), .TOKEN_TIMEOUT(TOKEN_TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .DO        (DO),
        .SCLK      (SCLK),
        .DI        (DI),
        .CS        (CS),
        .isStart   (isStart),
        .blockAddr (blockAddr),
        .isHighCap (isHighCap),
        .dataOut   (dataOut),
        .dataValid (dataValid),
        .isBusy    (isBusy),
        .isFinish  (isFinish),
        .isError   (isError),
        .errCode   (errCode)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAsserts++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] scriptByte(input int n);
        int m;
        if (n < 6) return 8'hFF;
        m = n - 6;
        if (noR1 || m < r1Delay) return 8'hFF;
        if (m == r1Delay) return r1Val;
        if (r1Val != 8'h00) return 8'hFF;
        m = m - r1Delay - 1;
        if (noTok) return m[0] ? 8'h55 : 8'hFF;
        if (m < tokDelay) return 8'hFF;
        if (m == tokDelay) return tokVal;
        if (tokVal != 8'hFE) return 8'hFF;
        m = m - tokDelay - 1;
        if (m < 512) return 8'(m);
        return (m == 512) ? 8'hA5 : 8'h5A;
    endfunction

    function automatic int dataIdx(input int n);
        int m;
        if (noR1 || noTok || r1Val != 8'h00 || tokVal != 8'hFE) return -1;
        m = n - 6 - r1Delay - 1 - tokDelay - 1;
        return (m >= 0 && m < 512) ? m : -1;
    endfunction

    assign DO = misoSh[7];

    // Card: samples DI on SCLK rise, shifts DO on SCLK fall, forgets everything while deselected.
    initial forever begin
        @(posedge SCLK or negedge SCLK or posedge CS or negedge reset);
        if (!reset || CS) begin
            cardBit = 0;
            byteNum = 0;
            misoSh  = 8'hFF;
        end else if (SCLK) begin
            mosiSh = {mosiSh[6:0], DI};
            cardBit++;
            if (cardBit == 8) begin
                cardBytes++;
                if (byteNum < 6) begin
                    logic [8:0] e;
                    e = (cmdQ.size() > 0) ? {1'b0, cmdQ.pop_front()} : 9'h100;
                    checkEq($sformatf("cmd%0d", byteNum), 32'(mosiSh), 32'(e));
                end
                byteNum++;
            end
        end else begin
            if (cardBit == 8) begin
                cardBit = 0;
                misoSh  = scriptByte(byteNum);
                if (dataIdx(byteNum) >= 0) expQ.push_back(8'(dataIdx(byteNum)));
            end else begin
                misoSh = {misoSh[6:0], 1'b1};
            end
        end
    end

    always @(posedge SCLK) if (CS) trailRises++;

    always @(negedge clk) begin
        if (dataValid) begin
            logic [8:0] e;
            e = (expQ.size() > 0) ? {1'b0, expQ.pop_front()} : 9'h100;
            checkEq($sformatf("data%0d", dvCount - baseDv), 32'(dataOut), 32'(e));
            dvCount++;
        end
    end

    task automatic setCard(input int r1d, input logic [7:0] r1v, input int tokd,
                           input logic [7:0] tokv, input bit nr1, input bit ntok);
        r1Delay = r1d; r1Val = r1v; tokDelay = tokd; tokVal = tokv; noR1 = nr1; noTok = ntok;
    endtask

    task automatic startRead(input bit hc, input logic [31:0] addr);
        logic [31:0] a;
        a = hc ? addr : (addr << 9);
        cmdQ.delete();
        expQ.delete();
        cmdQ.push_back(8'h51);
        cmdQ.push_back(a[31:24]);
        cmdQ.push_back(a[23:16]);
        cmdQ.push_back(a[15:8]);
        cmdQ.push_back(a[7:0]);
        cmdQ.push_back(8'hFF);
        baseBytes = cardBytes;
        baseDv    = dvCount;
        baseTrail = trailRises;
        isHighCap = hc;
        blockAddr = addr;
        @(negedge clk) isStart = 1'b1;
        @(negedge clk) isStart = 1'b0;
        checkEq("busy_after_start", 32'(isBusy), 32'd1);
    endtask

    task automatic waitEnd(input string tag);
        int n = 0;
        while (!(isFinish || isError) && n < READ_LIMIT) begin
            @(negedge clk);
            n++;
        end
        checkEq({tag, "_ended"}, 32'(isFinish | isError), 32'd1);
        repeat (10) @(negedge clk);
    endtask

    task automatic checkFullRead(input string tag);
        checkEq({tag, "_dv"}, 32'(dvCount - baseDv), 32'd512);
        checkEq({tag, "_finish"}, 32'(isFinish), 32'd1);
        checkEq({tag, "_error"}, 32'(isError), 32'd0);
        checkEq({tag, "_busy"}, 32'(isBusy), 32'd0);
        checkEq({tag, "_trail"}, 32'(trailRises - baseTrail), 32'd8);
        checkEq({tag, "_cs"}, 32'(CS), 32'd1);
        checkEq({tag, "_sclk"}, 32'(SCLK), 32'd0);
        checkEq({tag, "_expq"}, 32'(expQ.size()), 32'd0);
        checkEq({tag, "_cmdq"}, 32'(cmdQ.size()), 32'd0);
    endtask

    task automatic checkError(input string tag, input logic [7:0] code, input int bytes);
        checkEq({tag, "_error"}, 32'(isError), 32'd1);
        checkEq({tag, "_finish"}, 32'(isFinish), 32'd0);
        checkEq({tag, "_errcode"}, 32'(errCode), 32'(code));
        checkEq({tag, "_dv"}, 32'(dvCount - baseDv), 32'd0);
        checkEq({tag, "_cs"}, 32'(CS), 32'd1);
        checkEq({tag, "_busy"}, 32'(isBusy), 32'd0);
        if (bytes > 0) checkEq({tag, "_bytes"}, 32'(cardBytes - baseBytes), 32'(bytes));
    endtask

    initial begin
        int n;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        checkEq("rst_sclk", 32'(SCLK), 32'd0);
        checkEq("rst_di", 32'(DI), 32'd1);
        checkEq("rst_cs", 32'(CS), 32'd1);
        checkEq("rst_dataout", 32'(dataOut), 32'h00);
        checkEq("rst_dv", 32'(dataValid), 32'd0);
        checkEq("rst_busy", 32'(isBusy), 32'd0);
        checkEq("rst_finish", 32'(isFinish), 32'd0);
        checkEq("rst_error", 32'(isError), 32'd0);
        checkEq("rst_errcode", 32'(errCode), 32'h00);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Full SDHC read, with an isStart pulse mid-block that must be ignored.
        setCard(2, 8'h00, 5, 8'hFE, 1'b0, 1'b0);
        startRead(1'b1, 32'h0000_0010);
        n = 0;
        while ((dvCount - baseDv) < 50 && n < READ_LIMIT) begin
            @(negedge clk);
            n++;
        end
        blockAddr = 32'hDEAD_BEEF;
        isStart   = 1'b1;
        @(negedge clk) isStart = 1'b0;
        checkEq("busy_ignore_start", 32'(isBusy), 32'd1);
        waitEnd("hc");
        checkFullRead("hc");

        // Byte addressing, card rejects the command.
        setCard(1, 8'h04, 0, 8'hFE, 1'b0, 1'b0);
        startRead(1'b0, 32'h0000_0003);
        waitEnd("sc_r1");
        checkError("sc_r1", 8'h04, 6 + 2);

        // Byte addressing truncates the upper block-number bits.
        setCard(0, 8'h05, 0, 8'hFE, 1'b0, 1'b0);
        startRead(1'b0, 32'h0080_0001);
        waitEnd("sc_trunc");
        checkError("sc_trunc", 8'h05, 6 + 1);

        // Error token instead of the data token.
        setCard(0, 8'h00, 3, 8'h08, 1'b0, 1'b0);
        startRead(1'b1, 32'h1234_5678);
        waitEnd("tok_err");
        checkError("tok_err", 8'h08, 6 + 1 + 4);

        // Card never answers.
        setCard(0, 8'h00, 0, 8'hFE, 1'b1, 1'b0);
        startRead(1'b1, 32'h0000_0001);
        waitEnd("no_r1");
        checkError("no_r1", 8'hFF, 6 + 8);

        // R1 fine but no token; junk bytes count toward the timeout.
        setCard(1, 8'h00, 0, 8'hFE, 1'b0, 1'b1);
        startRead(1'b1, 32'h0000_0002);
        waitEnd("no_tok");
        checkError("no_tok", 8'hFF, 6 + 2 + TOKEN_TIMEOUT);

        // Reset in the middle of the data phase, then a clean read.
        setCard(0, 8'h00, 2, 8'hFE, 1'b0, 1'b0);
        startRead(1'b1, 32'h0000_0020);
        n = 0;
        while ((dvCount - baseDv) < 100 && n < READ_LIMIT) begin
            @(negedge clk);
            n++;
        end
        checkEq("mid_reached", 32'(dvCount - baseDv), 32'd100);
        #1 reset = 1'b0;
        #1;
        checkEq("mid_rst_cs", 32'(CS), 32'd1);
        checkEq("mid_rst_sclk", 32'(SCLK), 32'd0);
        checkEq("mid_rst_dv", 32'(dataValid), 32'd0);
        checkEq("mid_rst_busy", 32'(isBusy), 32'd0);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        expQ.delete();
        baseDv = dvCount;
        repeat (200) @(negedge clk);
        checkEq("post_rst_dv", 32'(dvCount - baseDv), 32'd0);
        checkEq("post_rst_busy", 32'(isBusy), 32'd0);
        checkEq("post_rst_sclk", 32'(SCLK), 32'd0);
        startRead(1'b1, 32'h0000_0020);
        waitEnd("after_rst");
        checkFullRead("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
